// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: oversampled 8N1 receiver with false-start and stop-bit checks,
// followed by a line parser that turns "<letter><CR|LF>" into command pulses.
module uart_cmd_rx #(
    parameter int DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       cmd_feed,
    output logic       cmd_play,
    output logic       cmd_clean,
    output logic       cmd_sleep,
    output logic       cmd_wake,
    output logic       cmd_status,
    output logic       cmd_err,
    output logic       busy
);

    localparam int CW = $clog2(DELAY_FRAMES) + 1;
    localparam logic [CW-1:0] HALF = CW'(DELAY_FRAMES / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DELAY_FRAMES - 1);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        P_EMPTY, P_HAVE, P_DISCARD
    } p_state_t;

    typedef enum logic [2:0] {
        C_FEED, C_PLAY, C_CLEAN, C_SLEEP, C_WAKE, C_STATUS
    } cmd_t;

    logic            sync1, rxs;
    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [2:0]      bit_idx, bit_next;
    logic [7:0]      shift, shift_next;
    logic [7:0]      data_next;
    logic            valid_next, ferr_next;

    p_state_t        p_state, p_next;
    cmd_t            code, code_next;
    logic [5:0]      cmd_vec, cmd_vec_next;
    logic            err_next;

    logic [7:0]      lc;
    logic            is_term, letter_hit;
    cmd_t            letter_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            rxs        <= 1'b1;
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            p_state    <= P_EMPTY;
            code       <= C_FEED;
            cmd_vec    <= '0;
            cmd_err    <= 1'b0;
        end else begin
            sync1      <= uart_rx;
            rxs        <= sync1;
            rx_state   <= rx_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            shift      <= shift_next;
            byte_data  <= data_next;
            byte_valid <= valid_next;
            frame_err  <= ferr_next;
            p_state    <= p_next;
            code       <= code_next;
            cmd_vec    <= cmd_vec_next;
            cmd_err    <= err_next;
        end
    end

    always_comb begin
        rx_next    = rx_state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        data_next  = byte_data;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (!rxs) begin
                    rx_next  = RX_START;
                    cnt_next = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_next = '0;
                    bit_next = '0;
                    rx_next  = rxs ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_next   = '0;
                    shift_next = {rxs, shift[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        rx_next = RX_STOP;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RX_STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                if (cnt == FULL) begin
                    cnt_next = '0;
                    if (rxs) begin
                        valid_next = 1'b1;
                        data_next  = shift;
                        rx_next    = RX_IDLE;
                    end else begin
                        ferr_next = 1'b1;
                        rx_next   = RX_BREAK;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RX_BREAK: begin
                if (rxs)
                    rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    assign lc      = byte_data | 8'h20;
    assign is_term = (byte_data == 8'h0D) || (byte_data == 8'h0A);

    always_comb begin
        letter_hit  = 1'b1;
        letter_code = C_FEED;
        unique case (1'b1)
            byte_data == 8'h3F: letter_code = C_STATUS;
            lc == 8'h66:        letter_code = C_FEED;
            lc == 8'h70:        letter_code = C_PLAY;
            lc == 8'h63:        letter_code = C_CLEAN;
            lc == 8'h73:        letter_code = C_SLEEP;
            lc == 8'h77:        letter_code = C_WAKE;
            default:            letter_hit  = 1'b0;
        endcase
    end

    always_comb begin
        p_next       = p_state;
        code_next    = code;
        cmd_vec_next = '0;
        err_next     = 1'b0;
        if (frame_err) begin
            p_next = P_DISCARD;
        end else if (byte_valid) begin
            unique case (p_state)
                P_EMPTY: begin
                    if (!is_term) begin
                        if (letter_hit) begin
                            code_next = letter_code;
                            p_next    = P_HAVE;
                        end else begin
                            p_next = P_DISCARD;
                        end
                    end
                end
                P_HAVE: begin
                    if (is_term) begin
                        cmd_vec_next = 6'd1 << code;
                        p_next       = P_EMPTY;
                    end else begin
                        p_next = P_DISCARD;
                    end
                end
                P_DISCARD: begin
                    if (is_term) begin
                        err_next = 1'b1;
                        p_next   = P_EMPTY;
                    end
                end
                default: p_next = P_EMPTY;
            endcase
        end
    end

    assign cmd_feed   = cmd_vec[C_FEED];
    assign cmd_play   = cmd_vec[C_PLAY];
    assign cmd_clean  = cmd_vec[C_CLEAN];
    assign cmd_sleep  = cmd_vec[C_SLEEP];
    assign cmd_wake   = cmd_vec[C_WAKE];
    assign cmd_status = cmd_vec[C_STATUS];
    assign busy       = (rx_state != RX_IDLE);

endmodule
